// File: rtl/issue_skid_stage.sv
// Two-entry register skid buffer between the warp round-robin prioritizer and the operand collector.
// Optional grant-protocol checker enabled by defining ISSUE_GRANT_CHECK_EN; otherwise err is tied low.
module issue_skid_stage #(
  parameter int NUM_WARPS = 8,
  parameter int INST_W    = 32,
  parameter int WID_W     = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_WARPS-1:0]        grt,
  input  logic [NUM_WARPS*INST_W-1:0] inst_flat,
  output logic                        can_accept,
  output logic [NUM_WARPS-1:0]        pop,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WID_W-1:0]            out_wid,
  output logic [INST_W-1:0]           out_inst,
  output logic [1:0]                  occupancy,
  output logic                        err
);

  typedef struct packed {
    logic [WID_W-1:0]  wid;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t [1:0] ent_q;
  logic         head_q, tail_q;
  logic [1:0]   occ_q;

  entry_t sel;
  logic   enq, deq;

  // Scan from the top so the lowest set bit wins if the grant is not one-hot.
  always_comb begin
    sel = '0;
    for (int i = NUM_WARPS-1; i >= 0; i--) begin
      if (grt[i]) begin
        sel.wid  = WID_W'(i);
        sel.inst = inst_flat[i*INST_W +: INST_W];
      end
    end
  end

  // can_accept depends only on registered occupancy, never on out_ready.
  assign can_accept = (occ_q != 2'd2);
  assign pop        = can_accept ? grt : '0;
  assign enq        = (|grt) && can_accept;
  assign out_valid  = (occ_q != 2'd0);
  assign deq        = out_valid && out_ready;
  assign out_wid    = ent_q[head_q].wid;
  assign out_inst   = ent_q[head_q].inst;
  assign occupancy  = occ_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_q  <= '0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      if (enq) begin
        ent_q[tail_q] <= sel;
        tail_q        <= ~tail_q;
      end
      if (deq) head_q <= ~head_q;
      case ({enq, deq})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

`ifdef ISSUE_GRANT_CHECK_EN
  logic err_q;
  logic multi_grt;

  assign multi_grt = |(grt & (grt - NUM_WARPS'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_q | multi_grt | ((|grt) && !can_accept);
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/issue_skid_stage.md
ISSUE_SKID_STAGE -- requirements
Module: issue_skid_stage

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 8: number of warps; equals the width of the upstream round-robin grant vector.
REQ-002 SHALL have parameter INST_W, default 32: instruction width.
REQ-003 SHALL have parameter WID_W, default 3: warp-id width, equal to clog2(NUM_WARPS).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port grt  input  NUM_WARPS  one-hot grant from the round-robin prioritizer; all-zero means no grant.
REQ-007 SHALL have port inst_flat  input  NUM_WARPS*INST_W  head instruction of each warp's ibuffer; warp i occupies bits [i*INST_W +: INST_W].
REQ-008 SHALL have port can_accept  output  1  high when the buffer is not full; upstream ANDs it into every request.
REQ-009 SHALL have port pop  output  NUM_WARPS  one-hot dequeue strobe to the granted warp's ibuffer.
REQ-010 SHALL have port out_valid  output  1  head entry valid toward the operand collector.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the head this cycle.
REQ-012 SHALL have port out_wid  output  WID_W  warp id of the head entry.
REQ-013 SHALL have port out_inst  output  INST_W  instruction of the head entry.
REQ-014 SHALL have port occupancy  output  2  number of valid entries, 0..2.
REQ-015 SHALL have port err  output  1  sticky grant-protocol error flag (see Configuration).

Function
REQ-016 SHALL implement a 2-entry in-order FIFO built from registers, with 1-bit head and tail pointers that wrap 1->0.
REQ-017 SHALL drive can_accept = (occupancy != 2), decoded from registered state only, with no combinational path from out_ready.
REQ-018 SHALL enqueue when |grt && can_accept: the entry stores wid = binary index of the lowest set bit of grt, and inst = that warp's slice of inst_flat.
REQ-019 SHALL drive pop = grt when can_accept is high, else all-zero; pop is combinational in the same cycle as the grant.
REQ-020 SHALL ignore a non-zero grt while full: no enqueue, pop = 0, state unchanged.
REQ-021 SHALL dequeue when out_valid && out_ready; out_valid = (occupancy != 0); out_wid and out_inst come from the head entry.
REQ-022 SHALL have a grant-to-out_valid latency of exactly 1 cycle when empty; there is no combinational bypass.
REQ-023 SHALL, on simultaneous enqueue and dequeue at occupancy 1, keep occupancy at 1 and present the new entry as head on the next cycle.
REQ-024 SHALL, on simultaneous enqueue and dequeue at occupancy 0, perform only the enqueue, because out_valid is low.
REQ-025 SHALL hold out_wid and out_inst stable while out_valid && !out_ready.
REQ-026 SHALL deliver entries in grant order with no loss or duplication.

Reset
REQ-027 SHALL, while rst is low, asynchronously clear occupancy, pointers, both entries' wid/inst and err to 0; outputs then read out_valid=0, can_accept=1, pop=0 (when grt=0), occupancy=0.
REQ-028 SHALL discard buffered entries if rst is asserted mid-operation; out_valid falls immediately without waiting for a clock edge.
REQ-029 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Configuration
REQ-030 SHALL, with macro ISSUE_GRANT_CHECK_EN defined, set err sticky-high on any edge where grt has more than one bit set, or where grt is non-zero while can_accept is low; err is cleared only by reset.
REQ-031 SHALL, with ISSUE_GRANT_CHECK_EN undefined, tie err to 0 and omit the checking logic; lowest-set-bit selection (REQ-018) still applies.

Verification
REQ-032 SHALL cover: reset, then grt=8'b0000_0100 with inst_flat slice2=0xDEADBEEF and out_ready=0 -> next cycle out_valid=1, out_wid=2, out_inst=0xDEADBEEF, occupancy=1; pop=8'b0000_0100 during the grant cycle.
REQ-033 SHALL cover: out_ready=0, grants to warp 1 then warp 5 -> occupancy=2, can_accept=0; a third grant to warp 7 -> pop=0, no enqueue; then out_ready=1 -> outputs wid 1 then wid 5.
REQ-034 SHALL cover: occupancy=1 holding warp 3, out_ready=1, same-cycle grant to warp 6 -> occupancy stays 1, next head wid=6.
REQ-035 SHALL cover: occupancy=2, rst pulsed low between clock edges -> out_valid=0 and occupancy=0 immediately, can_accept=1.
REQ-036 SHALL cover: grt=8'b1000_0001 -> wid 0 enqueued; err=1 and held with ISSUE_GRANT_CHECK_EN defined, err=0 without it.
REQ-037 SHALL cover: 1000 cycles of random one-hot grants gated by can_accept, with random out_ready -> the scoreboard sequence of (wid, inst) matches grant order exactly.
